// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion blocks.
// Holds the result width, default watchdog limit, accumulator width helper and
// the conversion sequencer state encoding, reused by the SAR logic variants.
package sar_pkg;

  localparam int unsigned SAR_DW      = 10;
  localparam int unsigned SAR_TIMEOUT = 64;

  // Up to 8 samples are summed, so three guard bits keep the sum exact.
  function automatic int unsigned sar_acc_w(input int unsigned dw);
    return dw + 3;
  endfunction

  localparam int unsigned SAR_ACC_W = sar_acc_w(SAR_DW);

  // Sequencer states kept as plain encoded constants for legacy tooling.
  typedef logic [2:0] sar_state_e;
  localparam sar_state_e StIdle  = 3'd0;
  localparam sar_state_e StArm   = 3'd1;
  localparam sar_state_e StStart = 3'd2;
  localparam sar_state_e StConv  = 3'd3;
  localparam sar_state_e StPush  = 3'd4;
  localparam sar_state_e StAbort = 3'd5;

endpackage

// File: rtl/sar_trig_timer.sv
// Trigger source for the conversion sequencer.
// Periodic counter (wraps at period-1, one trigger per wrap), registered
// rising-edge detector on ext_trig, and a mode mux producing a one-cycle trig.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   run           counter runs while high, held at zero otherwise
//   trig_mode     0 = periodic, 1 = external
//   ext_trig      raw external trigger
//   period        wrap length in cycles (>= 2)
//   trig          single-cycle trigger pulse (only while run is high)
module sar_trig_timer #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          trig_mode,
  input  logic          ext_trig,
  input  logic [PW-1:0] period,
  output logic          trig
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          ext_q, ext_prev_q;
  logic          wrap;
  logic          ext_edge;

  // >= rather than == so a counter somehow past the limit still wraps.
  assign wrap     = (cnt_q >= period - PW'(1));
  assign ext_edge = ext_q & ~ext_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      ext_q      <= 1'b0;
      ext_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ext_q      <= ext_trig;
      ext_prev_q <= ext_q;
    end
  end

  assign trig = run & (trig_mode ? ext_edge : wrap);

endmodule

// File: rtl/sar_conv_sequencer.sv
// Conversion sequencer for the SAR logic core.
// Issues cnvst from a periodic or external trigger, waits for eoc under a
// watchdog, averages 2^avg_log2 results and presents them on valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   en                       run enable
//   trig_mode/ext_trig       trigger source select / external trigger
//   period, avg_log2         config, latched when leaving IDLE
//   clr_flags                clears overrun and timeout_err
//   eoc, sar                 SAR core handshake and result
//   cnvst, adc_rst           SAR core start pulse and reset
//   dout/dout_valid/ready    averaged result stream
//   busy, overrun, timeout_err  status
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int unsigned DW      = SAR_DW,
  parameter int unsigned PW      = 16,
  parameter int unsigned TIMEOUT = SAR_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          trig_mode,
  input  logic          ext_trig,
  input  logic [PW-1:0] period,
  input  logic [1:0]    avg_log2,
  input  logic          clr_flags,
  input  logic          eoc,
  input  logic [DW-1:0] sar,
  output logic          cnvst,
  output logic          adc_rst,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err
);

  localparam int unsigned AccW = sar_acc_w(DW);
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sar_state_e    state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic          mode_q, mode_d;
  logic [1:0]    avg_q, avg_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic          abort_q, abort_d;

  logic          cnvst_q, adc_rst_q, dout_valid_q, busy_q, overrun_q, timeout_q;
  logic          cnvst_d, adc_rst_d, dout_valid_d, busy_d, overrun_d, timeout_d;
  logic [DW-1:0] dout_q, dout_d;

  logic          trig;
  logic          trig_drop;
  logic          push_drop;

  sar_trig_timer #(
    .PW(PW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != StIdle),
    .trig_mode(mode_q),
    .ext_trig (ext_trig),
    .period   (period_q),
    .trig     (trig)
  );

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    avg_d    = avg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    abort_d  = abort_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          period_d = period;
          mode_d   = trig_mode;
          avg_d    = avg_log2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (!en) begin
          state_d = StIdle;
        end else if (trig) begin
          state_d = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StConv;
      end
      StConv: begin
        // eoc wins over the watchdog on the final count.
        if (eoc) begin
          acc_d = acc_q + AccW'(sar);
          cnt_d = cnt_q + 4'd1;
          if (!en) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end else if (cnt_d == (4'd1 << avg_q)) begin
            state_d = StPush;
          end else begin
            state_d = StArm;
          end
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          abort_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAbort;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StPush: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = en ? StArm : StIdle;
      end
      StAbort: begin
        // Two cycles in ABORT give the two-cycle adc_rst pulse.
        if (!abort_q) begin
          abort_d = 1'b1;
        end else begin
          state_d = en ? StArm : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign trig_drop = trig && (state_q inside {StStart, StConv, StPush, StAbort});
  assign push_drop = (state_q == StPush) && dout_valid_q;

  always_comb begin
    cnvst_d      = (state_d == StStart);
    adc_rst_d    = (state_d == StAbort);
    busy_d       = (state_d != StIdle);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if ((state_q == StPush) && !dout_valid_q) begin
      dout_d       = DW'(acc_q >> avg_q);
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
    // Set events are ORed in after the clear so they win.
    overrun_d = (clr_flags ? 1'b0 : overrun_q) | trig_drop | push_drop;
    timeout_d = (clr_flags ? 1'b0 : timeout_q) |
                ((state_q == StConv) && (state_d == StAbort));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      period_q     <= '0;
      mode_q       <= 1'b0;
      avg_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      abort_q      <= 1'b0;
      cnvst_q      <= 1'b0;
      adc_rst_q    <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      mode_q       <= mode_d;
      avg_q        <= avg_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      abort_q      <= abort_d;
      cnvst_q      <= cnvst_d;
      adc_rst_q    <= adc_rst_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cnvst       = cnvst_q;
  assign adc_rst     = adc_rst_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
